// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding, legal word widths and the
// parity helper used by the configurable transmitter (and the planned receiver).
package uart_pkg;

    localparam int ST_W = $clog2(6);

    localparam logic [ST_W-1:0] ST_IDLE   = ST_W'(0);
    localparam logic [ST_W-1:0] ST_WAIT   = ST_W'(1);
    localparam logic [ST_W-1:0] ST_START  = ST_W'(2);
    localparam logic [ST_W-1:0] ST_DATA   = ST_W'(3);
    localparam logic [ST_W-1:0] ST_PARITY = ST_W'(4);
    localparam logic [ST_W-1:0] ST_STOP   = ST_W'(5);

    typedef enum logic [ST_W-1:0] {
        IDLE   = ST_IDLE,
        WAIT   = ST_WAIT,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_e;

    localparam int DW_MIN = 5;
    localparam int DW_MAX = 9;

    // Narrower words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_bit(input logic [DW_MAX-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word handshake, frame configuration, baud tick and serial-line signals of
// the configurable UART transmitter.
interface uart_tx_cfg_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  b_tick;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  parity_en;
    logic                  parity_odd;
    logic                  stop2;
    logic                  tx_busy;
    logic                  frame_done;
    logic                  tx;

    modport master (
        output b_tick, tx_valid, tx_data, parity_en, parity_odd, stop2,
        input  tx_ready, tx_busy, frame_done, tx
    );

    modport slave (
        input  b_tick, tx_valid, tx_data, parity_en, parity_odd, stop2,
        output tx_ready, tx_busy, frame_done, tx
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_WIDTH data bits LSB first, optional
// even/odd parity, 1 or 2 stop bits, each bit OSV_RATE baud ticks long.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OSV_RATE   = 16
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_cfg_if.slave bus
);

    localparam int TW = $clog2(OSV_RATE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OSV_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    uart_state_e           state_q;
    logic [TW-1:0]         tick_q;
    logic [BW-1:0]         bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_en_q;
    logic                  par_q;
    logic                  stop2_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  bit_end;

    assign bit_end         = bus.b_tick && (tick_q == TICK_LAST);
    assign bus.tx_ready    = (state_q == IDLE);
    assign bus.tx          = tx_q;
    assign bus.tx_busy     = busy_q;
    assign bus.frame_done  = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Line level trails the state by one clk.
            unique case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[0];
                PARITY:  tx_q <= par_q;
                default: tx_q <= 1'b1;
            endcase

            if (state_q != IDLE && state_q != WAIT && bus.b_tick)
                tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);

            unique case (state_q)
                IDLE: begin
                    if (bus.tx_valid) begin
                        shift_q  <= bus.tx_data;
                        par_en_q <= bus.parity_en;
                        par_q    <= parity_bit(DW_MAX'(bus.tx_data), bus.parity_odd);
                        stop2_q  <= bus.stop2;
                        busy_q   <= 1'b1;
                        state_q  <= WAIT;
                    end
                end
                // A tick on the accept edge is seen in IDLE, so it never counts here.
                WAIT: begin
                    if (bus.b_tick) begin
                        tick_q  <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) state_q <= DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
                            state_q <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) state_q <= STOP;
                end
                STOP: begin
                    if (bit_end) begin
                        // bit_q marks that the first of two stop bits is done.
                        if (stop2_q && bit_q == '0) begin
                            bit_q <= BW'(1);
                        end else begin
                            bit_q   <= '0;
                            tick_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It serialises one DATA_WIDTH-bit word per frame, LSB first, timed by the shared baud-tick generator (OSV_RATE ticks per bit).
- Adds a valid/ready handshake, optional even/odd parity, 1 or 2 stop bits, and a frame-done pulse.
- Sits between the command/FIFO logic and the tx pad of the dual-watch UART path.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- OSV_RATE, 16, b_tick pulses per bit period; must be ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- b_tick  in  1  one-clk pulse at OSV_RATE × baud rate
- tx_valid  in  1  word available on tx_data
- tx_ready  out  1  transmitter can accept a word
- tx_data  in  DATA_WIDTH  word to send
- parity_en  in  1  1 = append parity bit
- parity_odd  in  1  1 = odd parity, 0 = even; ignored when parity_en=0
- stop2  in  1  1 = two stop bits, 0 = one
- tx_busy  out  1  frame in progress
- frame_done  out  1  one-clk pulse when the final stop bit completes
- tx  out  1  serial line, idle high

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, tx=1, tx_busy=0, frame_done=0, all counters 0, data and config latches 0. tx_ready is combinational and equals (state==IDLE), so it reads 1 during and after reset. Inputs are ignored while rst=1.
- States: IDLE, WAIT, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_busy=0.
  - Accept on a clk edge where tx_valid & tx_ready.
  - On accept, latch tx_data, parity_en, parity_odd and stop2. Config changes after accept do not affect the current frame.
  - Compute and latch the parity bit at accept: XOR of the data bits, inverted when parity_odd=1.
  - Go to WAIT. tx_busy=1 from the next cycle.
- WAIT: tx_busy=1, tx=1. Wait for the first b_tick, then go to START with tick count 0. This aligns the frame start to the tick grid.
- START / DATA / PARITY / STOP:
  - Each bit lasts OSV_RATE b_ticks.
  - The tick counter has width $clog2(OSV_RATE). It increments on b_tick and wraps to 0 at OSV_RATE-1, which ends the bit.
- START: tx=0.
- DATA: tx = shift register bit 0.
  - At each bit end, shift right by 1 and increment the bit counter (width $clog2(DATA_WIDTH+1)).
  - After bit DATA_WIDTH-1, go to PARITY if the latched parity_en=1, otherwise go to STOP.
- PARITY: tx = latched parity bit for one bit period, then go to STOP.
- STOP: tx=1.
  - Lasts OSV_RATE ticks, or 2×OSV_RATE ticks when the latched stop2=1.
  - At completion: go to IDLE, pulse frame_done for one clk, clear the bit and tick counters.
- Registered output: tx is a register updated from the current state. The line changes one clk after the state changes.
- Frame length: 1 + OSV_RATE × (1 + DATA_WIDTH + P + S) b_ticks from accept, where P ∈ {0,1} and S ∈ {1,2}.
- b_tick coinciding with accept: the WAIT state ignores it. That tick does not count.
- Back-to-back frames: tx_ready is high in the first cycle back in IDLE. A held tx_valid is accepted there, and tx stays 1 through WAIT. The data sent is the value present at the accept edge, not the value when valid first rose.
- tx_valid while busy: tx_ready=0, the word is not accepted, nothing is lost or corrupted.
- Reset mid-frame: rst forces tx=1 and IDLE immediately (asynchronously). The partial frame is abandoned and frame_done is not pulsed.
- No b_tick: the state holds indefinitely; no timeout.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE..STOP, width $clog2(6));
  - the legal DATA_WIDTH range constants;
  - a parity function (data, odd) → bit, reusable by the planned uart_rx_cfg.
- No sub-module required. The tick/bit counter is small enough to stay inline; the baud-tick generator stays external.

Test Plan:
- DW=8, OSV=16, 0x55, parity_en=0, stop2=0 → tx after WAIT: 0 | 1,0,1,0,1,0,1,0 | 1, each held 16 ticks. frame_done pulses once at tick 1+160. tx_busy high throughout.
- 0x07 with parity_en=1, parity_odd=0 → parity bit=1; repeat with parity_odd=1 → parity bit=0. Frame is 1+176 ticks.
- stop2=1, parity_en=1 → stop level lasts 32 ticks. Toggling stop2 mid-frame has no effect; tx_ready stays 0 until frame_done.
- tx_valid held high with 0xA3 then 0x3C → two frames back to back, second accepted the cycle after frame_done. Gap between frames is exactly the WAIT alignment. LSB-first check on both words.
- rst asserted mid-DATA at bit 4 → tx=1 and tx_ready=1 in the same cycle, no frame_done. The next accepted word (0xFF) transmits a complete, correct frame.
- Parameter variant DW=5, OSV=4, data 0x1B, odd parity → 0 | 1,1,0,1,1 | 1 (4 ones → odd parity bit 1) | 1. Total 1+4×8 ticks.
